hazard_stall_ctrl: RTL and testbench

Pipeline stall/flush controller. It consumes the load-use stall request from the Decode-stage hazard detector, the taken-branch indication from Decode, and the data-memory handshake from the Memory stage. From these it drives the per-stage stall and flush enables of the five-stage pipeline registers. It also sequences multi-cycle data-memory waits through an FSM with a timeout watchdog, and keeps saturating performance counters.

---
 rtl/hazard_stall_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, branch flush, data-memory wait FSM.
// Ports: lwstall/branch_taken_d/mem_req_m/mem_ready_m in; stall_*/flush_*, mem_timeout, perf counters out.
module hazard_stall_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 255,
  parameter int TO_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lwstall,
  input  logic                 branch_taken_d,
  input  logic                 mem_req_m,
  input  logic                 mem_ready_m,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_w,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] lw_stall_cnt,
  output logic [CNT_WIDTH-1:0] mem_stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [TO_WIDTH-1:0] WAIT_LAST =
    TO_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [TO_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] lw_cnt_q, lw_cnt_d;
  logic [CNT_WIDTH-1:0] ms_cnt_q, ms_cnt_d;
  logic [CNT_WIDTH-1:0] fl_cnt_q, fl_cnt_d;

  logic freeze;
  logic hazard_ok;
  logic ms_count;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v,
    input logic                 en
  );
    if (en && v != CNT_MAX)
      return v + CNT_WIDTH'(1);
    return v;
  endfunction

  // Next-state and Mealy outputs.
  // freeze: whole front of the pipe held, MEM/WB bubbled.
  // hazard_ok: load-use / branch rules may act this cycle.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    hazard_ok     = 1'b0;
    ms_count      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_req_m && !mem_ready_m) begin
          freeze     = 1'b1;
          ms_count   = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end else begin
          hazard_ok = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!mem_ready_m) begin
          freeze   = 1'b1;
          ms_count = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = ST_ERR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_WIDTH'(1);
          end
        end else begin
          hazard_ok = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;

    if (!rst) begin
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hazard_ok) begin
        // Load-use wins over a taken branch: the
        // branch is re-resolved after the bubble.
        if (lwstall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (branch_taken_d) begin
          flush_d = 1'b1;
        end
      end
    end

    lw_cnt_d = sat_inc(lw_cnt_q, flush_e);
    ms_cnt_d = sat_inc(ms_cnt_q, stall_m && ms_count);
    fl_cnt_d = sat_inc(fl_cnt_q, flush_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      lw_cnt_q      <= '0;
      ms_cnt_q      <= '0;
      fl_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      lw_cnt_q      <= lw_cnt_d;
      ms_cnt_q      <= ms_cnt_d;
      fl_cnt_q      <= fl_cnt_d;
    end
  end

  assign mem_timeout   = mem_timeout_q;
  assign lw_stall_cnt  = lw_cnt_q;
  assign mem_stall_cnt = ms_cnt_q;
  assign flush_cnt     = fl_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int CW   = 3;
  localparam int TO   = 4;
  localparam int TOW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_FREEZE = 7'b1111001;
  localparam logic [6:0] O_LW     = 7'b1100010;
  localparam logic [6:0] O_BR     = 7'b0000100;

  logic clk = 1'b0;
  logic rst, lwstall, branch_taken_d;
  logic mem_req_m, mem_ready_m;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, mem_timeout;
  logic [CW-1:0] lw_stall_cnt, mem_stall_cnt, flush_cnt;
  logic [6:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode;
  int m_waits;
  int m_lw, m_ms, m_fl;
  bit m_to;
  logic [6:0] exp_out;
  bit exp_frozen;

  always #5 clk = ~clk;

  assign outs = {stall_f, stall_d, stall_e, stall_m,
                 flush_d, flush_e, flush_w};

  hazard_stall_ctrl #(
    .CNT_WIDTH(CW),
    .TIMEOUT  (TO),
    .TO_WIDTH (TOW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lwstall       (lwstall),
    .branch_taken_d(branch_taken_d),
    .mem_req_m     (mem_req_m),
    .mem_ready_m   (mem_ready_m),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .stall_e       (stall_e),
    .stall_m       (stall_m),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .flush_w       (flush_w),
    .mem_timeout   (mem_timeout),
    .lw_stall_cnt  (lw_stall_cnt),
    .mem_stall_cnt (mem_stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // Model modes: 0 running, 1 waiting on memory, 2 dead.
  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic drive(input bit r, input bit l,
                       input bit b, input bit q,
                       input bit y);
    @(negedge clk);
    rst            = r;
    lwstall        = l;
    branch_taken_d = b;
    mem_req_m      = q;
    mem_ready_m    = y;
    exp_frozen = !r && (m_mode == 2 ||
                        (m_mode == 1 && !y) ||
                        (m_mode == 0 && q && !y));
    if (r)               exp_out = O_IDLE;
    else if (exp_frozen) exp_out = O_FREEZE;
    else if (l)          exp_out = O_LW;
    else if (b)          exp_out = O_BR;
    else                 exp_out = O_IDLE;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_waits = 0; m_to = 0;
      m_lw = 0; m_ms = 0; m_fl = 0;
    end else begin
      if (exp_out[1]) m_lw = sat(m_lw + 1);
      if (exp_out[2]) m_fl = sat(m_fl + 1);
      if (exp_frozen && m_mode != 2) m_ms = sat(m_ms + 1);
      case (m_mode)
        0: if (exp_frozen) begin
          m_mode = 1; m_waits = 0;
        end
        1: if (!mem_ready_m) begin
          m_waits++;
          if (m_waits == TO) begin
            m_mode = 2; m_to = 1;
          end
        end else begin
          m_mode = 0;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic do_reset;
    drive(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset;
    drive(1, 1, 0, 1, 0);
    n_tests++;
    if (outs !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_outs0: got %b want %b", outs, O_IDLE);
    end
    tick();
    drive(1, 1, 1, 1, 0);
    n_tests++;
    if (outs !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_outs1: got %b want %b", outs, O_IDLE);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({lw_stall_cnt, mem_stall_cnt, flush_cnt, mem_timeout}
        !== 10'b0 || outs !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got cnt %0d/%0d/%0d to %b outs %b want 0",
               lw_stall_cnt, mem_stall_cnt, flush_cnt,
               mem_timeout, outs);
    end
  endtask

  task automatic test_lw_branch;
    do_reset();
    drive(0, 1, 1, 0, 0);
    n_tests++;
    if (outs !== O_LW) begin
      n_fail++;
      $display("FAIL lw_over_br: got %b want %b", outs, O_LW);
    end
    tick();
    drive(0, 0, 1, 0, 0);
    n_tests++;
    if (outs !== O_BR) begin
      n_fail++;
      $display("FAIL branch: got %b want %b", outs, O_BR);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (lw_stall_cnt !== CW'(1) || flush_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL lw_br_cnt: got lw %0d fl %0d want 1 1",
               lw_stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_mem_wait;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      n_tests++;
      if (outs !== O_FREEZE) begin
        n_fail++;
        $display("FAIL memwait_c%0d: got %b want %b",
                 i, outs, O_FREEZE);
      end
      tick();
    end
    drive(0, 0, 0, 1, 1);
    n_tests++;
    if (outs !== O_IDLE) begin
      n_fail++;
      $display("FAIL mem_release: got %b want %b", outs, O_IDLE);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (outs !== O_IDLE || mem_stall_cnt !== CW'(3)) begin
      n_fail++;
      $display("FAIL mem_after: got outs %b cnt %0d want %b 3",
               outs, mem_stall_cnt, O_IDLE);
    end
  endtask

  task automatic test_zero_wait;
    do_reset();
    drive(0, 0, 1, 1, 1);
    n_tests++;
    if (outs !== O_BR) begin
      n_fail++;
      $display("FAIL zero_wait: got %b want %b", outs, O_BR);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (outs !== O_IDLE || mem_stall_cnt !== CW'(0)) begin
      n_fail++;
      $display("FAIL zero_wait_after: got %b cnt %0d want %b 0",
               outs, mem_stall_cnt, O_IDLE);
    end
  endtask

  task automatic test_priority;
    do_reset();
    drive(0, 1, 1, 1, 0);
    n_tests++;
    if (outs !== O_FREEZE) begin
      n_fail++;
      $display("FAIL prio_run: got %b want %b", outs, O_FREEZE);
    end
    tick();
    drive(0, 1, 0, 0, 0);
    n_tests++;
    if (outs !== O_FREEZE || lw_stall_cnt !== CW'(0)) begin
      n_fail++;
      $display("FAIL prio_wait: got %b lw %0d want %b 0",
               outs, lw_stall_cnt, O_FREEZE);
    end
    tick();
    drive(0, 1, 0, 0, 1);
    n_tests++;
    if (outs !== O_LW) begin
      n_fail++;
      $display("FAIL prio_release: got %b want %b", outs, O_LW);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (mem_stall_cnt !== CW'(2) || lw_stall_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL prio_cnt: got ms %0d lw %0d want 2 1",
               mem_stall_cnt, lw_stall_cnt);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    drive(0, 0, 0, 1, 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 0, 0, 0, 0);
      n_tests++;
      if (outs !== O_FREEZE || mem_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait_c%0d: got %b to %b want %b 0",
                 c, outs, mem_timeout, O_FREEZE);
      end
      tick();
    end
    drive(0, 1, 1, 0, 1);
    n_tests++;
    if (outs !== O_FREEZE || mem_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_err: got %b to %b want %b 1",
               outs, mem_timeout, O_FREEZE);
    end
    tick();
    drive(0, 0, 0, 0, 1);
    n_tests++;
    if (outs !== O_FREEZE || mem_stall_cnt !== CW'(5)) begin
      n_fail++;
      $display("FAIL to_sticky: got %b ms %0d want %b 5",
               outs, mem_stall_cnt, O_FREEZE);
    end
    drive(1, 0, 0, 0, 0);
    n_tests++;
    if (outs !== O_IDLE) begin
      n_fail++;
      $display("FAIL to_rst: got %b want %b", outs, O_IDLE);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (outs !== O_IDLE || mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: got %b to %b want %b 0",
               outs, mem_timeout, O_IDLE);
    end
  endtask

  task automatic test_saturation;
    int want;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
      want = (i + 1 > CMAX) ? CMAX : i + 1;
      n_tests++;
      if (lw_stall_cnt !== CW'(want)) begin
        n_fail++;
        $display("FAIL sat_c%0d: got %0d want %0d",
                 i, lw_stall_cnt, want);
      end
    end
    drive(0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    n_tests++;
    if (outs !== O_IDLE) begin
      n_fail++;
      $display("FAIL midrst_outs: got %b want %b", outs, O_IDLE);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (outs !== O_IDLE || lw_stall_cnt !== CW'(0) ||
        mem_stall_cnt !== CW'(0)) begin
      n_fail++;
      $display("FAIL midrst_run: got %b lw %0d ms %0d want %b 0 0",
               outs, lw_stall_cnt, mem_stall_cnt, O_IDLE);
    end
  endtask

  task automatic test_random;
    bit r, l, b, q, y;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      q = ($urandom_range(0, 2) == 0);
      y = ($urandom_range(0, 9) < 6);
      drive(r, l, b, q, y);
      n_tests++;
      if (outs !== exp_out) begin
        n_fail++;
        $display("FAIL rand_outs_%0d: got %b want %b",
                 i, outs, exp_out);
      end
      tick();
      n_tests++;
      if (lw_stall_cnt !== CW'(m_lw) ||
          mem_stall_cnt !== CW'(m_ms) ||
          flush_cnt !== CW'(m_fl) ||
          mem_timeout !== m_to) begin
        n_fail++;
        $display("FAIL rand_regs_%0d: got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b",
                 i, lw_stall_cnt, mem_stall_cnt, flush_cnt,
                 mem_timeout, m_lw, m_ms, m_fl, m_to);
      end
    end
  endtask

  initial begin
    rst = 1'b1; lwstall = 1'b0; branch_taken_d = 1'b0;
    mem_req_m = 1'b0; mem_ready_m = 1'b0;
    m_mode = 0; m_waits = 0; m_to = 0;
    m_lw = 0; m_ms = 0; m_fl = 0;
    exp_out = '0; exp_frozen = 0;
    test_reset();
    test_lw_branch();
    test_mem_wait();
    test_zero_wait();
    test_priority();
    test_timeout();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
